// File: rtl/cpu_pipe_pkg.sv
// Shared widths and stage bundles for the 5-stage 64-bit pipeline register bank.
// Field order inside each struct fixes the bit layout seen by every stage.
package cpu_pipe_pkg;

    localparam int DATA_W  = 64;
    localparam int INSTR_W = 32;
    localparam int REG_W   = 5;

    // Operand-B select driven by decode; carried as raw bits in id_ex_t.ALUSrc
    typedef enum logic [1:0] {
        ALU_SRC_DB     = 2'b00,
        ALU_SRC_DADDR9 = 2'b01,
        ALU_SRC_IMM12  = 2'b10,
        ALU_SRC_LS     = 2'b11
    } alu_src_e;

    typedef struct packed {
        logic [DATA_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } if_id_t;

    typedef struct packed {
        logic               RegWrite;
        logic               MemWrite;
        logic [2:0]         ALUOp;
        logic [1:0]         ALUSrc;
        logic               MemToReg;
        logic               flagWrite;
        logic [DATA_W-1:0]  Imm12Ext;
        logic [DATA_W-1:0]  Daddr9Ext;
        logic [DATA_W-1:0]  LS;
        logic [REG_W-1:0]   Rd;
        logic [DATA_W-1:0]  Da;
        logic [DATA_W-1:0]  Db;
    } id_ex_t;

    typedef struct packed {
        logic               RegWrite;
        logic               MemWrite;
        logic               MemToReg;
        logic               FlagWrite;
        logic [REG_W-1:0]   Rd;
        logic [DATA_W-1:0]  ALUResult;
        logic [DATA_W-1:0]  Db;
        logic [DATA_W-1:0]  Daddr9Ext;
    } ex_mem_t;

endpackage

// File: rtl/pipe_reg.sv
// Purpose: WIDTH-bit register that loads every cycle, cleared asynchronously to zero.
// Latency: 1 cycle from d to q; q never depends combinationally on d.
// Backpressure: none -- no enable or hold, the register is overwritten each edge.
module pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipeline_stage_regs.sv
// Purpose: IF/ID, ID/EX and EX/MEM stage registers; reset zeroes all three into NOP bubbles.
// Latency: 1 cycle per stage, stages are independent.
// Backpressure: none -- every stage loads every cycle; the core has no stall or flush.
module pipeline_stage_regs
    import cpu_pipe_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  if_id_t  if_id_d,
    output if_id_t  if_id_q,
    input  id_ex_t  id_ex_d,
    output id_ex_t  id_ex_q,
    input  ex_mem_t ex_mem_d,
    output ex_mem_t ex_mem_q
);

    pipe_reg #(.WIDTH($bits(if_id_t))) u_if_id (
        .clk   (clk),
        .rst_n (reset),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    pipe_reg #(.WIDTH($bits(id_ex_t))) u_id_ex (
        .clk   (clk),
        .rst_n (reset),
        .d     (id_ex_d),
        .q     (id_ex_q)
    );

    pipe_reg #(.WIDTH($bits(ex_mem_t))) u_ex_mem (
        .clk   (clk),
        .rst_n (reset),
        .d     (ex_mem_d),
        .q     (ex_mem_q)
    );

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Bench for pipeline_stage_regs: driver pushes each captured bundle into per-stage queues,
// a monitor pops one entry per clock edge and compares the registered outputs.
module tb_pipeline_stage_regs;
    import cpu_pipe_pkg::*;

    logic    clk;
    logic    reset;
    if_id_t  if_id_d,  if_id_q;
    id_ex_t  id_ex_d,  id_ex_q;
    ex_mem_t ex_mem_d, ex_mem_q;

    int checks = 0;
    int errors = 0;

    if_id_t  sb_if[$];
    id_ex_t  sb_id[$];
    ex_mem_t sb_ex[$];

    if_id_t  last_if;
    id_ex_t  last_id;
    ex_mem_t last_ex;
    bit      have_last = 0;

    pipeline_stage_regs dut (
        .clk      (clk),
        .reset    (reset),
        .if_id_d  (if_id_d),
        .if_id_q  (if_id_q),
        .id_ex_d  (id_ex_d),
        .id_ex_q  (id_ex_q),
        .ex_mem_d (ex_mem_d),
        .ex_mem_q (ex_mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [399:0] act, input logic [399:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_if"}, 400'(if_id_q),  400'(0));
        chk({nm, "_id"}, 400'(id_ex_q),  400'(0));
        chk({nm, "_ex"}, 400'(ex_mem_q), 400'(0));
    endtask

    function automatic logic [399:0] rnd();
        logic [399:0] v;
        v = '0;
        for (int i = 0; i < 12; i++) v[i*32 +: 32] = $urandom;
        v[399:384] = 16'($urandom);
        return v;
    endfunction

    // Reference: a register loaded at an edge with reset high shows exactly the d it saw;
    // with reset low it shows zero.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            chk_all_zero("edge_rst");
            last_if = '0; last_id = '0; last_ex = '0;
            have_last = 1;
        end else if (sb_if.size() == 0 || sb_id.size() == 0 || sb_ex.size() == 0) begin
            chk("sb_underflow", 400'(sb_if.size()), 400'(1));
        end else begin
            last_if = sb_if.pop_front();
            last_id = sb_id.pop_front();
            last_ex = sb_ex.pop_front();
            have_last = 1;
            chk("if_id_q",  400'(if_id_q),  400'(last_if));
            chk("id_ex_q",  400'(id_ex_q),  400'(last_id));
            chk("ex_mem_q", 400'(ex_mem_q), 400'(last_ex));
        end
    end

    // Drive one cycle: inputs change at negedge; outputs must not move until the next edge.
    task automatic step(input if_id_t a, input id_ex_t b, input ex_mem_t c,
                        input logic rst_v, input bit chain);
        @(negedge clk);
        if (chain) begin
            b.Da        = if_id_q.pc;
            c.ALUResult = id_ex_q.Da;
        end
        if_id_d  = a;
        id_ex_d  = b;
        ex_mem_d = c;
        #1;
        if (!reset) begin
            chk_all_zero("mid_rst");
        end else if (have_last) begin
            chk("hold_if", 400'(if_id_q),  400'(last_if));
            chk("hold_id", 400'(id_ex_q),  400'(last_id));
            chk("hold_ex", 400'(ex_mem_q), 400'(last_ex));
        end
        if (!reset && rst_v) begin
            reset = 1'b1;
            #1;
            chk_all_zero("release_noglitch");
        end else begin
            reset = rst_v;
        end
        if (rst_v) begin
            sb_if.push_back(a);
            sb_id.push_back(b);
            sb_ex.push_back(c);
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        if_id_t  a;
        id_ex_t  b;
        ex_mem_t c;
        logic [399:0] v;

        reset    = 1'b0;
        if_id_d  = '1;
        id_ex_d  = '1;
        ex_mem_d = '1;

        // Load all-ones, then clear asynchronously and hold reset across three edges
        step('1, '1, '1, 1'b1, 0);
        async_reset();
        for (int i = 0; i < 3; i++) step('1, '1, '1, 1'b0, 0);

        a = '0; a.pc = 64'h40; a.instr = 32'h9100_0421;
        step(a, '0, '0, 1'b1, 0);

        b = '0;
        b.RegWrite = 1'b1; b.ALUOp = 3'b010; b.ALUSrc = 2'(ALU_SRC_IMM12);
        b.Imm12Ext = 64'h7FF; b.Da = 64'hDEAD_BEEF; b.Db = 64'h1234; b.Rd = 5'd3;
        step('0, b, '0, 1'b1, 0);

        for (int i = 1; i <= 8; i++) begin
            c = '0;
            c.ALUResult = 64'(i);
            c.MemWrite  = i[0];
            step('0, '0, c, 1'b1, 0);
        end

        a = '0; a.pc = 64'h8;
        step(a, '0, '0, 1'b1, 1);
        step('0, '0, '0, 1'b1, 1);
        step('0, '0, '0, 1'b1, 1);
        @(posedge clk);
        #2;
        chk("chain_ex_mem", 400'(ex_mem_q.ALUResult), 400'(64'h8));

        for (int n = 0; n < 200; n++) begin
            v = rnd(); a = v[$bits(if_id_t)-1:0];
            v = rnd(); b = v[$bits(id_ex_t)-1:0];
            v = rnd(); c = v[$bits(ex_mem_t)-1:0];
            step(a, b, c, 1'b1, 0);
            if ($urandom_range(0, 19) == 0) async_reset();
        end

        step('0, '0, '0, 1'b1, 0);
        @(posedge clk);
        #2;
        chk("sb_drain", 400'(sb_if.size()), 400'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
